// File: rtl/mem_line_ctrl.sv
// Line-granular main-memory controller: multi-beat READ_LINE/WRITE_LINE with fixed latency,
// optional post-reset LFSR fill of storage. Assumes LINE_BYTES is a power of two.
module mem_line_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int LINE_BYTES  = 16,
  parameter int MEM_LATENCY = 100,
  parameter int INIT_MODE   = 1,
  parameter int SEED        = 225526
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        C2_IN,
  input  logic [ADDR_W-1:0] A2_IN,
  input  logic [DATA_W-1:0] D2_IN,
  output logic [1:0]        C2_OUT,
  output logic [DATA_W-1:0] D2_OUT,
  output logic              READY,
  input  logic              M_DUMP
);

  // state   | meaning
  // INIT    | LFSR sweep, one byte per cycle
  // IDLE    | ready, accepts a command
  // WR_RECV | collecting write beats 1..BEATS-1
  // WAIT    | latency countdown
  // RESP    | RESPONSE beats on the bus
  localparam int BEATS   = LINE_BYTES * 8 / DATA_W;
  localparam int BPB     = DATA_W / 8;
  localparam int DEPTH   = LINE_BYTES << ADDR_W;
  localparam int BADDR_W = $clog2(DEPTH);
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int LINE_W  = LINE_BYTES * 8;
  localparam logic [31:0] LFSR_SEED = (SEED == 0) ? 32'd1 : 32'(SEED);
  localparam logic [31:0] TAPS      = 32'h8020_0003;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR_RECV, S_WAIT, S_RESP} state_t;

  state_t              state, state_next;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   line_q, line_next;
  logic                is_write_q, is_write_next;
  logic [BEAT_W-1:0]   beat_q, beat_next;
  logic [LAT_W-1:0]    wait_q, wait_next;
  logic [BADDR_W-1:0]  init_addr;
  logic [31:0]         lfsr, lfsr_adv;
  logic [LINE_W-1:0]   wbuf, wbuf_next;
  logic [DATA_W-1:0]   rd_beat;
  logic                capture, commit, dump_q;

  assign lfsr_adv = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);

  always_comb begin
    state_next    = state;
    line_next     = line_q;
    is_write_next = is_write_q;
    beat_next     = beat_q;
    wait_next     = wait_q;
    capture       = 1'b0;
    commit        = 1'b0;
    wbuf_next     = wbuf;
    for (int k = 0; k < BEATS; k++)
      if (beat_q == BEAT_W'(k)) wbuf_next[k*DATA_W +: DATA_W] = D2_IN;

    case (state)
      S_INIT: begin
        if (init_addr == BADDR_W'(DEPTH - 1)) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (C2_IN == 2'd2) begin
          line_next     = A2_IN;
          is_write_next = 1'b0;
          wait_next     = LAT_W'(MEM_LATENCY - 1);
          state_next    = S_WAIT;
        end else if (C2_IN == 2'd3) begin
          line_next     = A2_IN;
          is_write_next = 1'b1;
          capture       = 1'b1;
          if (BEATS == 1) begin
            commit     = 1'b1;
            wait_next  = LAT_W'(MEM_LATENCY - 1);
            state_next = S_WAIT;
          end else begin
            beat_next  = beat_q + 1'b1;
            state_next = S_WR_RECV;
          end
        end
      end
      S_WR_RECV: begin
        capture = 1'b1;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          commit     = 1'b1;
          beat_next  = '0;
          wait_next  = LAT_W'(MEM_LATENCY - 1);
          state_next = S_WAIT;
        end else begin
          beat_next = beat_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          beat_next  = '0;
          state_next = S_RESP;
        end else begin
          wait_next = wait_q - 1'b1;
        end
      end
      S_RESP: begin
        if (is_write_q || beat_q == BEAT_W'(BEATS - 1)) begin
          beat_next  = '0;
          state_next = S_IDLE;
        end else begin
          beat_next = beat_q + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the beat about to be presented is fetched here.
  always_comb begin
    rd_beat = '0;
    for (int b = 0; b < BPB; b++)
      rd_beat[b*8 +: 8] = mem[BADDR_W'(int'(line_q) * LINE_BYTES + int'(beat_next) * BPB + b)];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= (INIT_MODE != 0) ? S_INIT : S_IDLE;
      line_q     <= '0;
      is_write_q <= 1'b0;
      beat_q     <= '0;
      wait_q     <= '0;
      init_addr  <= '0;
      lfsr       <= LFSR_SEED;
      wbuf       <= '0;
      dump_q     <= 1'b0;
      C2_OUT     <= 2'd0;
      D2_OUT     <= '0;
      READY      <= 1'b0;
    end else begin
      state      <= state_next;
      line_q     <= line_next;
      is_write_q <= is_write_next;
      beat_q     <= beat_next;
      wait_q     <= wait_next;
      dump_q     <= M_DUMP;
      if (capture) wbuf <= wbuf_next;
      if (state == S_INIT) begin
        init_addr <= init_addr + 1'b1;
        lfsr      <= lfsr_adv;
      end
      READY  <= (state_next == S_IDLE);
      C2_OUT <= (state_next == S_RESP) ? 2'd1 : 2'd0;
      D2_OUT <= (state_next == S_RESP && !is_write_next) ? rd_beat : '0;
    end
  end

  // Storage is never reset; a write line lands only once its final beat is present.
  always_ff @(posedge CLK) begin
    if (state == S_INIT) mem[init_addr] <= lfsr[7:0];
    if (commit)
      for (int b = 0; b < LINE_BYTES; b++)
        mem[BADDR_W'(int'(line_next) * LINE_BYTES + b)] <= wbuf_next[b*8 +: 8];
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (M_DUMP && !dump_q && state == S_IDLE)
      for (int i = 0; i < DEPTH; i++) $display("mem_line_ctrl dump [%0d] = %02h", i, mem[i]);
  end
`endif

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed bench for mem_line_ctrl: two instances (LFSR fill / contents kept) share all inputs.
module tb_mem_line_ctrl;
  localparam int AW = 4, DW = 16, LB = 16, LAT = 5, BEATS = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [1:0]    C2_IN = 2'd0;
  logic [AW-1:0] A2_IN = '0;
  logic [DW-1:0] D2_IN = '0;
  logic          M_DUMP = 1'b0;
  logic [1:0]    c2_a, c2_b;
  logic [DW-1:0] d2_a, d2_b;
  logic          ready_a, ready_b;

  int checks = 0;
  int failures = 0;
  logic [7:0]  lfsr_bytes [256];
  logic [15:0] first_beat_a;

  always #5 CLK = ~CLK;

  mem_line_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .MEM_LATENCY(LAT),
                  .INIT_MODE(1), .SEED(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .C2_IN(C2_IN), .A2_IN(A2_IN), .D2_IN(D2_IN),
    .C2_OUT(c2_a), .D2_OUT(d2_a), .READY(ready_a), .M_DUMP(M_DUMP));

  mem_line_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .MEM_LATENCY(LAT),
                  .INIT_MODE(0), .SEED(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .C2_IN(C2_IN), .A2_IN(A2_IN), .D2_IN(D2_IN),
    .C2_OUT(c2_b), .D2_OUT(d2_b), .READY(ready_b), .M_DUMP(M_DUMP));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat_line(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [127:0] lfsr_line(input int line);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = lfsr_bytes[8'(line * 16 + i)];
    return r;
  endfunction

  task automatic wait_ready_both(input string tag);
    int n = 0;
    while (!(ready_a === 1'b1 && ready_b === 1'b1) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_ready_timeout"}, 32'(n >= 2000), 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] line, input logic [127:0] data, input string tag);
    int lat;
    C2_IN = 2'd3; A2_IN = line; D2_IN = data[15:0];
    for (int k = 1; k < BEATS; k++) begin
      @(negedge CLK);
      C2_IN = 2'd2; A2_IN = ~line; D2_IN = data[k*16 +: 16];
    end
    @(negedge CLK);
    C2_IN = 2'd0; A2_IN = '0; D2_IN = 16'hDEAD;
    lat = 0;
    while (c2_a !== 2'd1 && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_d2a_zero"}, 32'(d2_a), 32'd0);
    chk({tag, "_c2b"}, 32'(c2_b), 32'd1);
    chk({tag, "_d2b_zero"}, 32'(d2_b), 32'd0);
    @(negedge CLK);
    chk({tag, "_c2a_end"}, 32'(c2_a), 32'd0);
    chk({tag, "_ready"}, 32'({ready_a, ready_b}), 32'd3);
  endtask

  task automatic do_read(input logic [AW-1:0] line, input logic [127:0] exp_a,
                         input logic [127:0] exp_b, input bit chk_da, input bit chk_db,
                         input bit intrude, input string tag);
    int lat;
    C2_IN = 2'd2; A2_IN = line;
    @(negedge CLK);
    C2_IN = 2'd0; A2_IN = '0;
    lat = 0;
    while (c2_a !== 2'd1 && lat < 50) begin
      @(negedge CLK);
      lat++;
      if (intrude && lat == 2) begin
        C2_IN = 2'd2; A2_IN = line ^ 4'hF;
      end else begin
        C2_IN = 2'd0;
      end
    end
    C2_IN = 2'd0;
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_c2b"}, 32'(c2_b), 32'd1);
    for (int k = 0; k < BEATS; k++) begin
      if (k > 0) @(negedge CLK);
      if (k == 0) first_beat_a = d2_a;
      chk($sformatf("%s_c2a_b%0d", tag, k), 32'(c2_a), 32'd1);
      if (chk_da) chk($sformatf("%s_d2a_b%0d", tag, k), 32'(d2_a), 32'(exp_a[k*16 +: 16]));
      if (chk_db) chk($sformatf("%s_d2b_b%0d", tag, k), 32'(d2_b), 32'(exp_b[k*16 +: 16]));
    end
    @(negedge CLK);
    chk({tag, "_c2a_end"}, 32'(c2_a), 32'd0);
    chk({tag, "_d2a_end"}, 32'(d2_a), 32'd0);
    chk({tag, "_ready"}, 32'({ready_a, ready_b}), 32'd3);
    if (intrude) begin
      for (int i = 0; i < LAT + 3; i++) begin
        @(negedge CLK);
        chk({tag, "_no_extra_resp"}, 32'({c2_a, c2_b}), 32'd0);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lf;
    int n;
    lf = 32'd1;
    for (int i = 0; i < 256; i++) begin
      lfsr_bytes[8'(i)] = lf[7:0];
      lf = {1'b0, lf[31:1]} ^ (lf[0] ? 32'h8020_0003 : 32'd0);
    end

    // Test 1: reset state, INIT length, first line content
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'({ready_a, ready_b}), 32'd0);
    chk("rst_c2", 32'({c2_a, c2_b}), 32'd0);
    chk("rst_d2a", 32'(d2_a), 32'd0);
    RESET = 1'b0;
    n = 0;
    while (ready_a !== 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    chk("t1_init_cycles", 32'(n), 32'd256);
    chk("t1_ready_b", 32'(ready_b), 32'd1);
    do_read(4'd0, lfsr_line(0), '0, 1'b1, 1'b0, 1'b0, "t1_rd0");
    chk("t1_beat0_hand", 32'(first_beat_a), 32'h0301);

    // Test 2: write then read line 3
    do_write(4'd3, pat_line(8'h00), "t2_wr3");
    do_read(4'd3, pat_line(8'h00), pat_line(8'h00), 1'b1, 1'b1, 1'b0, "t2_rd3");

    // Test 3: command during WAIT is dropped
    do_read(4'd3, pat_line(8'h00), pat_line(8'h00), 1'b1, 1'b1, 1'b1, "t3_busy");

    // Tests 4 and 6: top/bottom lines, back-to-back accepts
    do_write(4'd15, pat_line(8'hA0), "t4_wr15");
    do_write(4'd0, pat_line(8'h50), "t4_wr0");
    do_read(4'd15, pat_line(8'hA0), pat_line(8'hA0), 1'b1, 1'b1, 1'b0, "t4_rd15");
    do_read(4'd0, pat_line(8'h50), pat_line(8'h50), 1'b1, 1'b1, 1'b0, "t6_rd0");
    do_read(4'd3, pat_line(8'h00), pat_line(8'h00), 1'b1, 1'b1, 1'b0, "t6_rd3");

    // Test 5: reset mid-burst, then reset mid-write
    C2_IN = 2'd2; A2_IN = 4'd3;
    @(negedge CLK);
    C2_IN = 2'd0;
    n = 0;
    while (c2_a !== 2'd1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("t5_lat", 32'(n), 32'(LAT));
    repeat (3) @(negedge CLK);
    chk("t5_beat3_d2b", 32'(d2_b), 32'h0706);
    RESET = 1'b1;
    #1;
    chk("t5_async_c2", 32'({c2_a, c2_b}), 32'd0);
    chk("t5_async_d2a", 32'(d2_a), 32'd0);
    chk("t5_async_d2b", 32'(d2_b), 32'd0);
    chk("t5_async_ready", 32'({ready_a, ready_b}), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    wait_ready_both("t5_rec1");
    do_read(4'd3, lfsr_line(3), pat_line(8'h00), 1'b1, 1'b1, 1'b0, "t5_rd3");

    C2_IN = 2'd3; A2_IN = 4'd3; D2_IN = 16'hBEEF;
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK);
      C2_IN = 2'd0; D2_IN = 16'hC0DE ^ 16'(k);
    end
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    wait_ready_both("t5_rec2");
    do_read(4'd3, lfsr_line(3), pat_line(8'h00), 1'b1, 1'b1, 1'b0, "t5_pw3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_line_ctrl.md
Name: mem_line_ctrl

Overview:
- Parametrised line-granular main-memory controller on the bus-2 side of the cache subsystem, next generation of the fixed-size memory model.
- Serves READ_LINE / WRITE_LINE with configurable latency, line size and bus width; returns data as multi-beat bursts.
- After reset, optionally refills storage with a reproducible pseudo-random pattern via a sequential sweep instead of an instantaneous reload.
- Exposes a ready flag and a simulation dump trigger.

Parameters:
- ADDR_W, 14, line-address width; storage = LINE_BYTES << ADDR_W bytes.
- DATA_W, 16, data bus width in bits; multiple of 8, divides LINE_BYTES*8.
- LINE_BYTES, 16, bytes per line; BEATS = LINE_BYTES*8/DATA_W.
- MEM_LATENCY, 100, cycles from command acceptance to first RESPONSE beat; >=1.
- INIT_MODE, 1, 0 = contents kept across reset; 1 = LFSR fill after reset.
- SEED, 225526, LFSR seed; 0 is replaced by 1.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- C2_IN  in  2  command from cache: 0 NOP, 2 READ_LINE, 3 WRITE_LINE.
- A2_IN  in  ADDR_W  line address, sampled only on the acceptance cycle.
- D2_IN  in  DATA_W  write data beat.
- C2_OUT  out  2  0 NOP, 1 RESPONSE.
- D2_OUT  out  DATA_W  read data beat; 0 when not in a read response.
- READY  out  1  high only in IDLE.
- M_DUMP  in  1  simulation only: rising edge while IDLE prints all bytes via $display.

Behaviour:
- Reset, asynchronous: C2_OUT=0, D2_OUT=0, READY=0, counters cleared. State goes to INIT if INIT_MODE=1, else IDLE. Reset mid-burst aborts at once with no partial response; a partially received write leaves storage unchanged.
- States: INIT, IDLE, WR_RECV, WAIT, RESP.
- INIT:
  - One byte per cycle, byte address 0 upward.
  - Byte = lfsr[7:0]. The LFSR is a 32-bit Galois register, taps mask 0x80200003, shift right, loaded with SEED at reset, advanced once after each byte.
  - Lasts exactly LINE_BYTES<<ADDR_W cycles, then IDLE.
  - Commands are ignored during INIT.
- IDLE:
  - READY=1.
  - C2_IN=2: latch A2_IN, go to WAIT.
  - C2_IN=3: latch A2_IN and capture D2_IN as beat 0. Go to WR_RECV if BEATS>1, else WAIT.
  - NOP or any other code: stay in IDLE.
- WR_RECV: capture D2_IN on each of the next BEATS-1 cycles, regardless of C2_IN, then go to WAIT. The line is committed to storage atomically on entry to WAIT.
- WAIT: counter runs so the first RESPONSE cycle is exactly MEM_LATENCY cycles after the acceptance edge for reads, or after the last data-beat edge for writes.
- RESP, read:
  - C2_OUT=1 for BEATS consecutive cycles.
  - Beat k carries bytes at line offsets k*DATA_W/8 upward; lowest byte goes in D2_OUT[7:0] (little-endian).
- RESP, write: C2_OUT=1 for one cycle, D2_OUT=0.
- After RESP: next cycle C2_OUT=0, READY=1, new command accepted that same cycle.
- Busy: commands arriving outside IDLE are dropped, not queued.
- Addresses: full ADDR_W range is valid, no wrap or aliasing. Byte address = {line, offset}.

Test Plan:
Config for all: ADDR_W=4, DATA_W=16, LINE_BYTES=16, MEM_LATENCY=5, SEED=1.
1. INIT_MODE=1, reset pulse: READY low for exactly 256 cycles, then high. A read of line 0 returns beat 0 = {byte1, byte0} matching the bench LFSR model (byte0 = 0x01).
2. WRITE_LINE line 3 with beats 0x0100, 0x0302, ..., 0x0F0E: one RESPONSE cycle 5 cycles after beat 7. Then READ_LINE line 3: first RESPONSE 5 cycles after acceptance, 8 beats equal to the written beats in order.
3. READ_LINE issued during WAIT of a previous read: ignored. Exactly 8 RESPONSE beats, from the first address only.
4. Write line 15 (top), then line 0: both read back correctly, no aliasing.
5. RESET asserted at beat 3 of a read: C2_OUT=0 and D2_OUT=0 immediately without a clock edge. With INIT_MODE=0, earlier-written line 3 still reads back unchanged.
6. Back-to-back: READ_LINE asserted the cycle READY returns is accepted; latency is again exactly 5.
